vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage, the successor to the fixed 640x480 driver. It runs from the pixel clock, generates programmable horizontal/vertical timing with selectable sync polarity, and issues pixel-coordinate requests to the upstream frame source. It accepts colour data after a configurable source latency and drives registered, mutually aligned sync, data-enable and RGB outputs to the DAC/resistor ladder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync
- R_W / G_W / B_W, 3 / 3 / 2, colour channel widths
- PIX_LAT, 1, cycles from pix_req to valid colors (1..4)
- clk25MHz  in  1  pixel clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en  in  1  clock enable; low freezes all state
- colors  in  R_W+G_W+B_W  pixel {R,G,B}, MSB-first, valid PIX_LAT cycles after its pix_req
- pix_req  out  1  requested pixel lies in active area
- pix_x  out  clog2(H_ACTIVE)  requested column
- pix_y  out  clog2(V_ACTIVE)  requested row
- frame_start  out  1  one-cycle pulse at pixel (0,0) request
- hsync / vsync  out  1  sync outputs, polarity per HS_POL/VS_POL
- de  out  1  active-video enable, aligned with RGB
- red / green / blue  out  R_W / G_W / B_W  pixel outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- hcnt counts 0..H_TOTAL-1, wraps to 0; on wrap vcnt increments, wrapping at V_TOTAL-1 to 0. Both advance only when en=1.
- Region order per axis: active [0,ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
- Stage 0 (counter stage): pix_req = hcnt<H_ACTIVE && vcnt<V_ACTIVE; pix_x/pix_y = hcnt/vcnt when pix_req else 0; frame_start = (hcnt==0 && vcnt==0).
- hs_raw/vs_raw/de_raw computed from counters, delayed through PIX_LAT-stage shift register, then registered with colors into outputs.
- red/green/blue = colors fields when delayed de=1, else 0. Blanking forces zero regardless of colors.
- Sync output = POL when in sync region, ~POL otherwise.
- en=0: counters, delay pipeline and output registers hold; outputs remain static.
- Counter widths: clog2(H_TOTAL), clog2(V_TOTAL); elaboration error if any porch/sync parameter is 0 or PIX_LAT outside 1..4.

## Timing
- Reset (async assert, sync deassert by upstream): hcnt=vcnt=0, pipeline cleared; hsync=~HS_POL, vsync=~VS_POL, de=0, RGB=0, pix_req=0, pix_x=pix_y=0, frame_start=0.
- First rising edge after reset release with en=1: counters become (0,0) view; pix_req and frame_start assert combinationally from counter state (registered counters, decoded outputs).
- Latency pix_req -> de/RGB/hsync/vsync: PIX_LAT+1 enabled cycles; all four outputs exactly aligned.
- Reset mid-frame: immediate return to reset values; pixel data in pipeline discarded; next frame starts at (0,0).
- Frame wrap (799,524)->(0,0): frame_start pulses exactly one enabled cycle per frame.
- vsync edges coincide with hcnt==0 of the relevant line (after pipeline delay).

## Configuration
- VGA_TESTPATTERN_EN defined: extra input pattern_sel (1 bit); when 1, colors is ignored and RGB carries eight vertical colour bars, bar index = pix_x / (H_ACTIVE/8), each channel all-ones/zeros from index bits {2,1,0} = {R,G,B}, pipelined with identical latency.
- Undefined: no pattern_sel port, no bar logic; RGB comes only from colors.

## Structure
- Package vga_pkg: default 640x480@60 timing constants, polarity constants, region enum (ACTIVE, FP, SYNC, BP).
- Sub-module vga_axis_counter (parametrised ACTIVE/FP/SYNC/BP): counter, wrap strobe, region decode; instantiated once per axis, horizontal wrap drives vertical increment.

## Test plan
- Defaults, en=1, run 2 frames -> hsync period 800, low for 96 cycles starting 656+PIX_LAT+1 after line start; vsync period 420000 cycles, low for 1600.
- Defaults, colors=8'hE3 constant -> red=3'b111, green=3'b000, blue=2'b11 exactly when de=1; 640x480=307200 de cycles/frame; RGB=0 elsewhere.
- PIX_LAT=3, colors driven as {pix_x[7:0]} delayed 3 cycles -> output pixel n equals n[7:0] on every active cycle, no shift.
- HS_POL=1, VS_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> hsync high 3 of 24 cycles; vsync high 24 of 168; frame_start once per 168.
- Toggle en low for 10 cycles mid-line -> all outputs frozen; line length remains 800 enabled cycles.
- Assert rst at (300,200) -> same cycle hsync/vsync inactive, de=0, RGB=0; after release frame_start pulses on first enabled cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults, types and helpers for the VGA raster generator (640x480@60 timing).
// VGA_TESTPATTERN_EN adds the colour-bar index to the pipeline record.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;

  localparam int DEF_R_W     = 3;
  localparam int DEF_G_W     = 3;
  localparam int DEF_B_W     = 2;
  localparam int DEF_PIX_LAT = 1;

  typedef enum logic [1:0] {
    RG_ACTIVE,
    RG_FP,
    RG_SYNC,
    RG_BP
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_e;

  // Sync bits hold "inside sync region"; polarity is applied at the output register.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
`ifdef VGA_TESTPATTERN_EN
    logic [2:0] bar;
`endif
  } pipe_t;

`ifdef VGA_TESTPATTERN_EN
  function automatic logic [2:0] bar_index(input int x, input int active);
    int bar_w;
    bar_w = (active / 8 > 0) ? active / 8 : 1;
    return 3'(x / bar_w);
  endfunction
`endif

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-clock signal bundle between vga_timing_gen (master) and frame source / DAC (slave).
// VGA_TESTPATTERN_EN adds the pattern_sel input.
interface vga_timing_gen_if #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  logic                   en;
  logic [R_W+G_W+B_W-1:0] colors;
`ifdef VGA_TESTPATTERN_EN
  logic                   pattern_sel;
`endif
  logic                   pix_req;
  logic [XW-1:0]          pix_x;
  logic [YW-1:0]          pix_y;
  logic                   frame_start;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [R_W-1:0]         red;
  logic [G_W-1:0]         green;
  logic [B_W-1:0]         blue;

`ifdef VGA_TESTPATTERN_EN
  modport master (
    input  en, colors, pattern_sel,
    output pix_req, pix_x, pix_y, frame_start, hsync, vsync, de, red, green, blue
  );
  modport slave (
    output en, colors, pattern_sel,
    input  pix_req, pix_x, pix_y, frame_start, hsync, vsync, de, red, green, blue
  );
`else
  modport master (
    input  en, colors,
    output pix_req, pix_x, pix_y, frame_start, hsync, vsync, de, red, green, blue
  );
  modport slave (
    output en, colors,
    input  pix_req, pix_x, pix_y, frame_start, hsync, vsync, de, red, green, blue
  );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with region decode, advancing only on inc_i.
// wrap_o marks the increment that returns the count to zero (chains horizontal into vertical).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int  ACTIVE = 640,
  parameter int  FP     = 16,
  parameter int  SYNC   = 96,
  parameter int  BP     = 48,
  localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int CW     = $clog2(TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output region_e       region_o
);

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FP_START = CW'(ACTIVE);
  localparam logic [CW-1:0] SY_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] BP_START = CW'(ACTIVE + FP + SYNC);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_cfg
    $error("vga_axis_counter: active, porch and sync lengths must all be non-zero");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && (cnt_q == LAST);

  always_comb begin
    if (cnt_q < FP_START) begin
      region_o = RG_ACTIVE;
    end else if (cnt_q < SY_START) begin
      region_o = RG_FP;
    end else if (cnt_q < BP_START) begin
      region_o = RG_SYNC;
    end else begin
      region_o = RG_BP;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel requests decoded from counters, sync/de/RGB registered PIX_LAT+1 enabled cycles later.
// en low freezes everything; VGA_TESTPATTERN_EN adds pattern_sel to swap colors for eight vertical bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = POL_NEG,
  parameter bit VS_POL   = POL_NEG,
  parameter int R_W      = DEF_R_W,
  parameter int G_W      = DEF_G_W,
  parameter int B_W      = DEF_B_W,
  parameter int PIX_LAT  = DEF_PIX_LAT
) (
  input logic              clk25MHz,
  input logic              rst,
  vga_timing_gen_if.master vif
);

  localparam int HCW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VCW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int CW  = R_W + G_W + B_W;

  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must lie in 1..4");
  end

  // The first enabled edge after reset only arms the generator, so (0,0) is presented for a full cycle.
  run_state_e state_q, state_d;

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && vif.en) begin
      state_d = ST_RUN;
    end
  end

  logic running;
  assign running = (state_q == ST_RUN);

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           h_inc, h_wrap, v_wrap_unused;
  region_e        h_region, v_region;

  assign h_inc = vif.en && running;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_hcnt (
    .clk_i    (clk25MHz),
    .rst_i    (rst),
    .inc_i    (h_inc),
    .cnt_o    (hcnt),
    .wrap_o   (h_wrap),
    .region_o (h_region)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_vcnt (
    .clk_i    (clk25MHz),
    .rst_i    (rst),
    .inc_i    (h_wrap),
    .cnt_o    (vcnt),
    .wrap_o   (v_wrap_unused),
    .region_o (v_region)
  );

  logic in_active;
  assign in_active       = running && (h_region == RG_ACTIVE) && (v_region == RG_ACTIVE);
  assign vif.pix_req     = in_active;
  assign vif.pix_x       = in_active ? XW'(hcnt) : '0;
  assign vif.pix_y       = in_active ? YW'(vcnt) : '0;
  assign vif.frame_start = running && (hcnt == '0) && (vcnt == '0);

  pipe_t raw;

  always_comb begin
    raw    = '0;
    raw.de = in_active;
    raw.hs = running && (h_region == RG_SYNC);
    raw.vs = running && (v_region == RG_SYNC);
`ifdef VGA_TESTPATTERN_EN
    raw.bar = bar_index(int'(vif.pix_x), H_ACTIVE);
`endif
  end

  // Timing bits wait here for the frame source to return the requested pixel.
  pipe_t pipe_q [PIX_LAT];

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (vif.en) begin
      pipe_q[0] <= raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  pipe_t tail;
  assign tail = pipe_q[PIX_LAT-1];

  logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [R_W-1:0] red_q, red_d, src_r;
  logic [G_W-1:0] green_q, green_d, src_g;
  logic [B_W-1:0] blue_q, blue_d, src_b;

  always_comb begin
    src_r = vif.colors[CW-1 -: R_W];
    src_g = vif.colors[B_W +: G_W];
    src_b = vif.colors[0 +: B_W];
`ifdef VGA_TESTPATTERN_EN
    if (vif.pattern_sel) begin
      src_r = {R_W{tail.bar[2]}};
      src_g = {G_W{tail.bar[1]}};
      src_b = {B_W{tail.bar[0]}};
    end
`endif
    hsync_d = tail.hs ? HS_POL : ~HS_POL;
    vsync_d = tail.vs ? VS_POL : ~VS_POL;
    de_d    = tail.de;
    red_d   = tail.de ? src_r : '0;
    green_d = tail.de ? src_g : '0;
    blue_d  = tail.de ? src_b : '0;
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (vif.en) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
  assign vif.de    = de_q;
  assign vif.red   = red_q;
  assign vif.green = green_q;
  assign vif.blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 24x7 raster (PIX_LAT=3, hsync active-high, vsync active-low).
// Outputs are predicted from the count of enabled cycles since reset and the colour history.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int HIST = 16384;

  logic clk25;
  logic rst;

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  vga_timing_gen_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .R_W(3), .G_W(3), .B_W(2)) vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .R_W(3), .G_W(3), .B_W(2), .PIX_LAT(LAT)
  ) dut (
    .clk25MHz (clk25),
    .rst      (rst),
    .vif      (vif)
  );

  int checks;
  int errors;
  int en_cnt;
  logic [7:0] col_hist [HIST];

  typedef struct {
    int         frames;
    bit         en_rand;
    logic [7:0] col;
    int         exp_de;
    int         exp_hs;
    int         exp_vs;
    int         exp_fs;
    logic [2:0] exp_r;
    logic [2:0] exp_g;
    logic [1:0] exp_b;
  } row_t;

  row_t rows [4];

  // State s means s enabled edges since reset; s=1 is the first (0,0) view.
  function automatic void pos_of(input int s, output bit run, output int h, output int v);
    run = (s >= 1);
    h   = run ? (s - 1) % HT : 0;
    v   = run ? ((s - 1) / HT) % VT : 0;
  endfunction

  function automatic logic [18:0] act_vec();
    return {vif.pix_req, vif.pix_x, vif.pix_y, vif.frame_start,
            vif.hsync, vif.vsync, vif.de, vif.red, vif.green, vif.blue};
  endfunction

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    bit run0, run1, req, fs, de, hs, vs;
    int h0, v0, h1, v1;
    logic [7:0] c;
    logic [18:0] exp_v, got_v;
    pos_of(en_cnt, run0, h0, v0);
    req = run0 && h0 < HA && v0 < VA;
    fs  = run0 && h0 == 0 && v0 == 0;
    pos_of(en_cnt - LAT - 1, run1, h1, v1);
    de  = run1 && h1 < HA && v1 < VA;
    hs  = run1 && h1 >= HA + HF && h1 < HA + HF + HSW;
    vs  = run1 && v1 >= VA + VF && v1 < VA + VF + VSW;
    c   = de ? col_hist[(en_cnt - 1) % HIST] : 8'h00;
    exp_v = {req, 4'(req ? h0 : 0), 2'(req ? v0 : 0), fs,
             (hs ? HP : !HP), (vs ? VP : !VP), de, c};
    got_v = act_vec();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle state=%0d: got %h expected %h", en_cnt, got_v, exp_v);
    end
  endtask

  task automatic step(input bit e, input logic [7:0] c);
    vif.en     = e;
    vif.colors = c;
    @(posedge clk25);
    if (e) begin
      col_hist[en_cnt % HIST] = c;
      en_cnt++;
    end
    #1;
    check_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise[$];
    int act_cnt, rise0, rise1, found, diffs, cyc, guard;
    int n_de, n_hs, n_vs, n_fs, bad_rgb;
    bit prev_hs, e, run0;
    int h0, v0;
    logic [18:0] snap;

    rows[0] = '{1, 1'b0, 8'hE3,  64, 21, 24, 1, 3'b111, 3'b000, 2'b11};
    rows[1] = '{2, 1'b1, 8'h1C, 128, 42, 48, 2, 3'b000, 3'b111, 2'b00};
    rows[2] = '{1, 1'b1, 8'hA5,  64, 21, 24, 1, 3'b101, 3'b001, 2'b01};
    rows[3] = '{3, 1'b0, 8'h00, 192, 63, 72, 3, 3'b000, 3'b000, 2'b00};

    checks = 0;
    errors = 0;
    en_cnt = 0;
    rst = 1'b1;
    vif.en = 1'b0;
    vif.colors = 8'h00;
`ifdef VGA_TESTPATTERN_EN
    vif.pattern_sel = 1'b0;
`endif
    repeat (3) @(posedge clk25);
    #1;
    expect_eq("rst_hsync", vif.hsync, HP ? 0 : 1);
    expect_eq("rst_vsync", vif.vsync, VP ? 0 : 1);
    expect_eq("rst_de", vif.de, 0);
    expect_eq("rst_rgb", {vif.red, vif.green, vif.blue}, 0);
    expect_eq("rst_pix_req", vif.pix_req, 0);
    expect_eq("rst_frame_start", vif.frame_start, 0);
    rst = 1'b0;

    step(1'b0, 8'h55);
    step(1'b0, 8'hAA);
    step(1'b1, 8'h12);
    expect_eq("first_pix_req", vif.pix_req, 1);
    expect_eq("first_frame_start", vif.frame_start, 1);
    expect_eq("first_pix_x", vif.pix_x, 0);

    // Horizontal sync placement relative to the line's first request.
    act_cnt = 0;
    prev_hs = !HP;
    for (int i = 1; i <= 3 * HT; i++) begin
      step(1'b1, 8'($urandom));
      if (vif.hsync == HP && prev_hs != HP) rise.push_back(i);
      if (vif.hsync == HP && rise.size() == 1) act_cnt++;
      prev_hs = vif.hsync;
    end
    rise0 = (rise.size() > 0) ? rise[0] : -1;
    rise1 = (rise.size() > 1) ? rise[1] : -1;
    expect_eq("hs_first_rise", rise0, HA + HF + LAT + 1);
    expect_eq("hs_period", rise1 - rise0, HT);
    expect_eq("hs_width", act_cnt, HSW);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 4) != 0, 8'($urandom));
    end

    // Freeze mid-line with de high on the output.
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      step(1'b1, 8'($urandom));
      pos_of(en_cnt, run0, h0, v0);
      if (h0 == 8 && v0 == 1) found = 1;
    end
    expect_eq("freeze_locate", found, 1);
    expect_eq("freeze_de_high", vif.de, 1);
    snap = act_vec();
    diffs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'($urandom));
      if (act_vec() !== snap) diffs++;
    end
    expect_eq("freeze_hold", diffs, 0);

    foreach (rows[r]) begin
      for (int k = 0; k < LAT + 2; k++) step(1'b1, rows[r].col);
      cyc = 0; guard = 0;
      n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; bad_rgb = 0;
      while (cyc < rows[r].frames * FRAME && guard < 8 * FRAME * rows[r].frames) begin
        e = rows[r].en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        guard++;
        step(e, rows[r].col);
        if (e) begin
          cyc++;
          if (vif.de) n_de++;
          if (vif.hsync == HP) n_hs++;
          if (vif.vsync == VP) n_vs++;
          if (vif.frame_start) n_fs++;
          if (vif.de && {vif.red, vif.green, vif.blue} != {rows[r].exp_r, rows[r].exp_g, rows[r].exp_b})
            bad_rgb++;
          if (!vif.de && {vif.red, vif.green, vif.blue} != 8'h00) bad_rgb++;
        end
      end
      expect_eq($sformatf("row%0d_cycles", r), cyc, rows[r].frames * FRAME);
      expect_eq($sformatf("row%0d_de", r), n_de, rows[r].exp_de);
      expect_eq($sformatf("row%0d_hsync", r), n_hs, rows[r].exp_hs);
      expect_eq($sformatf("row%0d_vsync", r), n_vs, rows[r].exp_vs);
      expect_eq($sformatf("row%0d_frame_start", r), n_fs, rows[r].exp_fs);
      expect_eq($sformatf("row%0d_rgb", r), bad_rgb, 0);
    end

    // Asynchronous reset in the middle of an active line.
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      step(1'b1, 8'($urandom));
      pos_of(en_cnt, run0, h0, v0);
      if (h0 == 10 && v0 == 2) found = 1;
    end
    expect_eq("midrst_locate", found, 1);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("midrst_hsync", vif.hsync, HP ? 0 : 1);
    expect_eq("midrst_vsync", vif.vsync, VP ? 0 : 1);
    expect_eq("midrst_de", vif.de, 0);
    expect_eq("midrst_rgb", {vif.red, vif.green, vif.blue}, 0);
    expect_eq("midrst_pix_req", vif.pix_req, 0);
    en_cnt = 0;
    @(posedge clk25);
    #1;
    rst = 1'b0;
    check_cycle();
    step(1'b1, 8'h3C);
    expect_eq("midrst_frame_start", vif.frame_start, 1);
    for (int i = 0; i < FRAME + 10; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
